// File: rtl/pll_supervisor_pkg.sv
// ---------------------------------------------------------------------------
// pll_supervisor_pkg
// Shared definitions for the PLL lock supervisor: the FSM state encoding,
// which is also exported on the debug/CSR "state" port, and its width.
// ---------------------------------------------------------------------------
package pll_supervisor_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAULT     = 3'd5
   } state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// ---------------------------------------------------------------------------
// pll_lock_sync
// Two-flop synchroniser that brings the asynchronous PLL LOCK output into
// the reference-clock domain. Adds two cycles of latency.
//
// Ports:
//   clk_i   in  reference clock
//   rst_ni  in  asynchronous active-low reset (both flops clear to 0)
//   async_i in  asynchronous input (raw PLL LOCK)
//   sync_o  out synchronised copy of async_i
// ---------------------------------------------------------------------------
module pll_lock_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
// PLL bring-up and supervision sequencer running in the PLL reference-clock
// domain. Pulses the PLL reset, qualifies LOCK (debounce + timeout + retry),
// releases the downstream domain resets in staggered order and re-runs the
// whole sequence whenever lock is lost.
//
// Ports:
//   input_clk    in  reference clock (same clock as PLL CLKI)
//   reset_n      in  asynchronous active-low reset
//   pll_locked   in  raw PLL LOCK (asynchronous)
//   restart      in  single-cycle restart request, highest priority
//   pll_reset    out 1 = PLL held in reset
//   domain_reset out 1 = domain held in reset, bit 0 released first
//   ready        out all domains released and lock healthy
//   fault        out retry budget exhausted
//   state        out current FSM state (pll_supervisor_pkg::state_e)
//   loss_count   out lock-loss event counter, saturating at 255
//                    (present only when PLL_SUPERVISOR_LOSS_COUNT_EN is
//                    defined; cleared only by reset_n)
//
// Optional feature macro: PLL_SUPERVISOR_LOSS_COUNT_EN
// ---------------------------------------------------------------------------
module pll_lock_supervisor
   import pll_supervisor_pkg::*;
#(
   parameter int NUM_DOMAINS         = 4,
   parameter int RST_PULSE_CYCLES    = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int STAGGER_CYCLES      = 8,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                   input_clk,
   input  logic                   reset_n,
   input  logic                   pll_locked,
   input  logic                   restart,
   output logic                   pll_reset,
   output logic [NUM_DOMAINS-1:0] domain_reset,
   output logic                   ready,
   output logic                   fault,
   output logic [STATE_W-1:0]     state
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
   ,
   output logic [7:0]             loss_count
`endif
);

   // Last RELEASE cycle index: the cycle on which the highest domain bit
   // drops. RUN is entered on the following edge.
   localparam int REL_LIM = (NUM_DOMAINS - 1) * STAGGER_CYCLES;

   localparam int PUL_W = $clog2(RST_PULSE_CYCLES) + 1;
   localparam int STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
   localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
   localparam int REL_W = $clog2(REL_LIM + 1) + 1;
   localparam int RTY_W = $clog2(MAX_RETRIES) + 1;

   logic                   lock_s;

   state_e                 state_q, state_d;
   logic [PUL_W-1:0]       pulse_q, pulse_d;
   logic [STB_W-1:0]       stb_q, stb_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [REL_W-1:0]       rel_q, rel_d;
   logic [RTY_W-1:0]       retry_q, retry_d;

   logic                   pll_reset_q, pll_reset_d;
   logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
   logic                   ready_q, ready_d;
   logic                   fault_q, fault_d;

   logic                   tmo_hit;
   logic [RTY_W-1:0]       retry_inc;
   state_e                 tmo_state;

   pll_lock_sync u_lock_sync (
      .clk_i   (input_clk),
      .rst_ni  (reset_n),
      .async_i (pll_locked),
      .sync_o  (lock_s)
   );

   always_comb begin
      state_d = state_q;
      pulse_d = pulse_q;
      stb_d   = stb_q;
      tmo_d   = tmo_q;
      rel_d   = rel_q;
      retry_d = retry_q;

      // tmo_q counts completed WAIT_LOCK/STABLE cycles of this attempt, so
      // the timeout fires on the LOCK_TIMEOUT_CYCLES-th cycle.
      tmo_hit   = (tmo_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 1));
      retry_inc = (retry_q == {RTY_W{1'b1}}) ? retry_q : retry_q + RTY_W'(1);
      tmo_state = ((MAX_RETRIES != 0) && (retry_inc == RTY_W'(MAX_RETRIES)))
                  ? FAULT : RESET_PLL;

      if (restart) begin
         state_d = RESET_PLL;
         pulse_d = '0;
         retry_d = '0;
      end else begin
         unique case (state_q)
            RESET_PLL: begin
               if (pulse_q == PUL_W'(RST_PULSE_CYCLES - 1)) begin
                  state_d = WAIT_LOCK;
                  tmo_d   = '0;
               end else begin
                  pulse_d = pulse_q + PUL_W'(1);
               end
            end
            WAIT_LOCK: begin
               if (tmo_hit) begin
                  state_d = tmo_state;
                  retry_d = retry_inc;
                  pulse_d = '0;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
                  if (lock_s) begin
                     state_d = STABLE;
                     stb_d   = '0;
                  end
               end
            end
            STABLE: begin
               // Completing the stable count beats a coincident timeout.
               if (lock_s && (stb_q == STB_W'(LOCK_STABLE_CYCLES - 1))) begin
                  state_d = RELEASE;
                  rel_d   = '0;
               end else if (tmo_hit) begin
                  state_d = tmo_state;
                  retry_d = retry_inc;
                  pulse_d = '0;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
                  if (!lock_s) begin
                     state_d = WAIT_LOCK;
                  end else begin
                     stb_d = stb_q + STB_W'(1);
                  end
               end
            end
            RELEASE: begin
               if (!lock_s) begin
                  state_d = RESET_PLL;
                  pulse_d = '0;
               end else if (rel_q == REL_W'(REL_LIM)) begin
                  state_d = RUN;
                  retry_d = '0;
               end else begin
                  rel_d = rel_q + REL_W'(1);
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_d = RESET_PLL;
                  pulse_d = '0;
               end
            end
            FAULT: begin
               state_d = FAULT;
            end
            default: begin
               state_d = RESET_PLL;
               pulse_d = '0;
            end
         endcase
      end
   end

   // Outputs are registered from the next state so every reset line changes
   // cleanly on the same edge as the state register.
   always_comb begin
      pll_reset_d = (state_d == RESET_PLL) || (state_d == FAULT);
      ready_d     = (state_d == RUN);
      fault_d     = (state_d == FAULT);
      dom_rst_d   = '1;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         if (state_d == RUN) begin
            dom_rst_d[i] = 1'b0;
         end else if (state_d == RELEASE) begin
            dom_rst_d[i] = (int'(rel_d) < i * STAGGER_CYCLES);
         end
      end
   end

   always_ff @(posedge input_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RESET_PLL;
         pulse_q     <= '0;
         stb_q       <= '0;
         tmo_q       <= '0;
         rel_q       <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         dom_rst_q   <= '1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pulse_q     <= pulse_d;
         stb_q       <= stb_d;
         tmo_q       <= tmo_d;
         rel_q       <= rel_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         dom_rst_q   <= dom_rst_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_reset    = pll_reset_q;
   assign domain_reset = dom_rst_q;
   assign ready        = ready_q;
   assign fault        = fault_q;
   assign state        = state_q;

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
   logic [7:0] loss_cnt_q, loss_cnt_d;
   logic       loss_ev;

   // A lock-loss exit only counts when restart is not taking priority.
   always_comb begin
      loss_ev    = !restart && !lock_s && ((state_q == RELEASE) || (state_q == RUN));
      loss_cnt_d = loss_cnt_q;
      if (loss_ev && (loss_cnt_q != 8'hFF)) begin
         loss_cnt_d = loss_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge input_clk or negedge reset_n) begin
      if (!reset_n) begin
         loss_cnt_q <= 8'd0;
      end else begin
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign loss_count = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with small parameters
// (RST_PULSE=4, STABLE=8, TIMEOUT=32, STAGGER=2, NUM_DOMAINS=4,
// MAX_RETRIES=2). Edge numbers Pn in the comments count rising edges after
// reset_n is released; values are checked 1 time unit after each edge.
// Optional macro: PLL_SUPERVISOR_LOSS_COUNT_EN (adds loss_count checks).
// ---------------------------------------------------------------------------
module tb_pll_lock_supervisor;

   logic       clk;
   logic       rst_n;
   logic       locked;
   logic       restart;
   logic       pll_reset;
   logic [3:0] domain_reset;
   logic       ready;
   logic       fault;
   logic [2:0] state;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
   logic [7:0] loss_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   pll_lock_supervisor #(
      .NUM_DOMAINS         (4),
      .RST_PULSE_CYCLES    (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32),
      .STAGGER_CYCLES      (2),
      .MAX_RETRIES         (2)
   ) dut (
      .input_clk    (clk),
      .reset_n      (rst_n),
      .pll_locked   (locked),
      .restart      (restart),
      .pll_reset    (pll_reset),
      .domain_reset (domain_reset),
      .ready        (ready),
      .fault        (fault),
      .state        (state)
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
      ,
      .loss_count   (loss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [2:0] st, input logic pr,
                           input logic [3:0] dr, input logic rd, input logic ft);
      chk({tag, ".state"},     32'(state),        32'(st));
      chk({tag, ".pll_reset"}, 32'(pll_reset),    32'(pr));
      chk({tag, ".dom"},       32'(domain_reset), 32'(dr));
      chk({tag, ".ready"},     32'(ready),        32'(rd));
      chk({tag, ".fault"},     32'(fault),        32'(ft));
   endtask

   initial begin
      rst_n   = 1'b0;
      locked  = 1'b0;
      restart = 1'b0;
      cyc(3);
      chk_outs("reset", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
      chk("reset.loss", 32'(loss_count), 32'd0);
`endif

      // Nominal bring-up
      rst_n = 1'b1;
      cyc(3);                                            // P3
      chk_outs("pulse_end", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
      cyc(1);                                            // P4
      chk_outs("wait_lock", 3'd1, 1'b0, 4'hF, 1'b0, 1'b0);
      cyc(3);                                            // P7
      locked = 1'b1;
      cyc(2);                                            // P9
      chk("sync_lat.state", 32'(state), 32'd1);
      cyc(1);                                            // P10
      chk("stable_entry", 32'(state), 32'd2);
      cyc(7);                                            // P17
      chk_outs("stable_last", 3'd2, 1'b0, 4'hF, 1'b0, 1'b0);
      cyc(1);                                            // P18 = RELEASE+0
      chk_outs("rel0", 3'd3, 1'b0, 4'hE, 1'b0, 1'b0);
      cyc(2);                                            // +2
      chk("rel2.dom", 32'(domain_reset), 32'hC);
      cyc(2);                                            // +4
      chk("rel4.dom", 32'(domain_reset), 32'h8);
      cyc(2);                                            // +6
      chk_outs("rel6", 3'd3, 1'b0, 4'h0, 1'b0, 1'b0);
      cyc(1);                                            // +7, P25
      chk_outs("run", 3'd4, 1'b0, 4'h0, 1'b1, 1'b0);

      // Restart from RUN, then lock glitch in STABLE at stable count 5
      restart = 1'b1;
      cyc(1);                                            // P26
      restart = 1'b0;
      chk_outs("restart_run", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
      cyc(4);                                            // P30
      chk("re_wait", 32'(state), 32'd1);
      cyc(1);                                            // P31
      chk("re_stable", 32'(state), 32'd2);
      cyc(3);                                            // P34
      locked = 1'b0;
      cyc(1);                                            // P35
      locked = 1'b1;
      cyc(1);                                            // P36
      chk("glitch_pre", 32'(state), 32'd2);
      cyc(1);                                            // P37
      chk_outs("glitch_wait", 3'd1, 1'b0, 4'hF, 1'b0, 1'b0);
      cyc(1);                                            // P38
      chk("glitch_restable", 32'(state), 32'd2);
      cyc(7);                                            // P45
      chk_outs("glitch_cnt_restart", 3'd2, 1'b0, 4'hF, 1'b0, 1'b0);
      cyc(1);                                            // P46
      chk("glitch_rel.dom", 32'(domain_reset), 32'hE);
      cyc(7);                                            // P53
      chk("run2.ready", 32'(ready), 32'd1);

      // Lock loss in RUN
      locked = 1'b0;
      cyc(2);                                            // P55
      chk_outs("loss_pre", 3'd4, 1'b0, 4'h0, 1'b1, 1'b0);
      cyc(1);                                            // P56
      chk_outs("loss", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
      chk("loss.count", 32'(loss_count), 32'd1);
`endif

      // Timeout / retry with lock held low
      cyc(35);                                           // P91
      chk("tmo1_pre", 32'(state), 32'd1);
      cyc(1);                                            // P92
      chk_outs("tmo1", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
      cyc(35);                                           // P127
      chk("tmo2_pre", 32'(state), 32'd1);
      cyc(1);                                            // P128
      chk_outs("fault", 3'd5, 1'b1, 4'hF, 1'b0, 1'b1);
      cyc(7);                                            // P135
      chk_outs("fault_hold", 3'd5, 1'b1, 4'hF, 1'b0, 1'b1);

      // Restart from FAULT clears the retry budget: two more timeouts needed
      restart = 1'b1;
      cyc(1);                                            // P136
      restart = 1'b0;
      chk_outs("restart_fault", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
      cyc(35);                                           // P171
      chk("rtmo1_pre", 32'(state), 32'd1);
      cyc(1);                                            // P172
      chk_outs("rtmo1", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
      cyc(35);                                           // P207
      chk("rtmo2_pre", 32'(state), 32'd1);
      cyc(1);                                            // P208
      chk_outs("refault", 3'd5, 1'b1, 4'hF, 1'b0, 1'b1);
      restart = 1'b1;
      cyc(1);                                            // P209
      restart = 1'b0;
      chk_outs("restart_fault2", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);

      // Restart mid-RELEASE
      locked = 1'b1;
      cyc(4);                                            // P213
      chk("mr_wait", 32'(state), 32'd1);
      cyc(1);                                            // P214
      chk("mr_stable", 32'(state), 32'd2);
      cyc(8);                                            // P222
      chk_outs("mr_rel0", 3'd3, 1'b0, 4'hE, 1'b0, 1'b0);
      cyc(2);                                            // P224
      chk("mr_rel2.dom", 32'(domain_reset), 32'hC);
      restart = 1'b1;
      cyc(1);                                            // P225
      restart = 1'b0;
      chk_outs("restart_rel", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
      cyc(20);                                           // P245
      chk_outs("run3", 3'd4, 1'b0, 4'h0, 1'b1, 1'b0);
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
      chk("run3.loss", 32'(loss_count), 32'd1);
`endif

      // Asynchronous reset between clock edges
      #3;
      rst_n = 1'b0;
      #1;
      chk_outs("async_rst", 3'd0, 1'b1, 4'hF, 1'b0, 1'b0);
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
      chk("async_rst.loss", 32'(loss_count), 32'd0);
`endif
      cyc(2);
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
